// File: rtl/data_mem_io.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_io                                                  |
// | Description : Data RAM with memory-mapped output ports, registered input   |
// |               ports, per-port change flags, a flag mask and a registered   |
// |               interrupt request.                                           |
// | Config      : DATA_MEM_IO_SYNC2_EN -> two-flop synchroniser on each input  |
// |               port (otherwise a single registered input stage).            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_mem_io #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int N_PORTS = 8,
  parameter int IO_BASE = 'hE0
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        WRITE_MEM,
  input  logic [ADDR_W-1:0]           ADDRESS,
  input  logic [DATA_W-1:0]           DATA_IN,
  input  logic [N_PORTS*DATA_W-1:0]   PORT_IN,
  output logic [DATA_W-1:0]           DATA_OUT,
  output logic [N_PORTS*DATA_W-1:0]   PORT_OUT,
  output logic                        IRQ
);

`ifdef DATA_MEM_IO_SYNC2_EN
  localparam int c_STAGES = 2;
`else
  localparam int c_STAGES = 1;
`endif

  localparam int                  c_DEPTH     = 1 << ADDR_W;
  // Width of the offset inside the 4*N_PORTS-word I/O window.
  localparam int                  c_OFF_W     = $clog2(4 * N_PORTS);
  // Arm counter counts 0..c_STAGES+1, then holds.
  localparam int                  c_ARM_W     = $clog2(c_STAGES + 2);
  localparam logic [c_ARM_W-1:0]  c_ARM_MAX   = c_ARM_W'(c_STAGES + 1);
  localparam logic [ADDR_W:0]     c_IO_LO     = (ADDR_W+1)'(IO_BASE);
  localparam logic [ADDR_W:0]     c_IO_HI     = (ADDR_W+1)'(IO_BASE + 4 * N_PORTS);
  localparam logic [c_OFF_W-1:0]  c_OFF_FLAGS = c_OFF_W'(2 * N_PORTS);
  localparam logic [c_OFF_W-1:0]  c_OFF_MASK  = c_OFF_W'(2 * N_PORTS + 1);

  // Storage and state
  logic [DATA_W-1:0]          r_mem [c_DEPTH];
  logic [N_PORTS*DATA_W-1:0]  r_stg [c_STAGES];
  logic [N_PORTS*DATA_W-1:0]  r_prev;
  logic [N_PORTS*DATA_W-1:0]  r_port_out;
  logic [N_PORTS-1:0]         r_flags;
  logic [N_PORTS-1:0]         r_mask;
  logic [c_ARM_W-1:0]         r_arm;
  logic                       r_irq;

  // Decode and datapath wires
  logic                       w_io_sel;
  logic [c_OFF_W-1:0]         w_off;
  logic                       w_wr_ram;
  logic                       w_wr_io;
  logic                       w_wr_flags;
  logic                       w_wr_mask;
  logic [N_PORTS*DATA_W-1:0]  w_s;
  logic                       w_armed;
  logic [N_PORTS-1:0]         w_new_evt;
  logic [N_PORTS-1:0]         w_clr;
  logic [DATA_W-1:0]          w_rd_io;

  // The I/O window is aligned to its own size, so the low address bits are
  // the offset within it. Everything outside the window is RAM.
  assign w_io_sel   = ({1'b0, ADDRESS} >= c_IO_LO) && ({1'b0, ADDRESS} < c_IO_HI);
  assign w_off      = ADDRESS[c_OFF_W-1:0];
  assign w_wr_ram   = WRITE_MEM && !RESET && !w_io_sel;
  assign w_wr_io    = WRITE_MEM && w_io_sel;
  assign w_wr_flags = w_wr_io && (w_off == c_OFF_FLAGS);
  assign w_wr_mask  = w_wr_io && (w_off == c_OFF_MASK);
  assign w_clr      = w_wr_flags ? DATA_IN[N_PORTS-1:0] : '0;

  // Last sampling stage is the value software sees and the change detector compares.
  assign w_s        = r_stg[c_STAGES-1];
  assign w_armed    = (r_arm == c_ARM_MAX);

  // Per-port change detection: current sample against the one-cycle-old copy.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_evt
    assign w_new_evt[gi] = w_armed &&
                           (w_s[gi*DATA_W +: DATA_W] != r_prev[gi*DATA_W +: DATA_W]);
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (w_wr_ram) begin
      r_mem[ADDRESS] <= DATA_IN;
    end
  end

  // Output port registers, one word per port address.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_port_out <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (w_wr_io && (w_off == c_OFF_W'(i))) begin
          r_port_out[i*DATA_W +: DATA_W] <= DATA_IN;
        end
      end
    end
  end

  // Input sampling pipeline plus the delayed copy used for change detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < c_STAGES; k++) begin
        r_stg[k] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_stg[0] <= PORT_IN;
      for (int k = 1; k < c_STAGES; k++) begin
        r_stg[k] <= r_stg[k-1];
      end
      r_prev <= w_s;
    end
  end

  // Arm counter: keeps detection off until the pipeline has filled after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_arm <= '0;
    end else if (!w_armed) begin
      r_arm <= r_arm + c_ARM_W'(1);
    end
  end

  // Event flags (set beats clear), mask register and registered interrupt.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_flags <= '0;
      r_mask  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_flags <= (r_flags & ~w_clr) | w_new_evt;
      if (w_wr_mask) begin
        r_mask <= DATA_IN[N_PORTS-1:0];
      end
      r_irq <= |(r_flags & r_mask);
    end
  end

  // I/O read mux; reserved offsets fall through to zero.
  always_comb begin
    w_rd_io = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_off == c_OFF_W'(i)) begin
        w_rd_io = r_port_out[i*DATA_W +: DATA_W];
      end
      if (w_off == c_OFF_W'(N_PORTS + i)) begin
        w_rd_io = w_s[i*DATA_W +: DATA_W];
      end
    end
    if (w_off == c_OFF_FLAGS) begin
      w_rd_io = DATA_W'(r_flags);
    end
    if (w_off == c_OFF_MASK) begin
      w_rd_io = DATA_W'(r_mask);
    end
  end

  assign DATA_OUT = w_io_sel ? w_rd_io : r_mem[ADDRESS];
  assign PORT_OUT = r_port_out;
  assign IRQ      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_io.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_mem_io                                               |
// | Description : Self-checking bench for data_mem_io (default parameters).    |
// |               Directed scenarios followed by a randomized phase, all       |
// |               checked against a behavioural model kept in this file.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_data_mem_io;

  localparam int N = 8;
  localparam int B = 'hE0;
`ifdef DATA_MEM_IO_SYNC2_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif
  localparam logic [7:0] A_FLAGS = 8'(B + 2*N);
  localparam logic [7:0] A_MASK  = 8'(B + 2*N + 1);

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        WRITE_MEM = 1'b0;
  logic [7:0]  ADDRESS = '0;
  logic [7:0]  DATA_IN = '0;
  logic [63:0] PORT_IN = '0;
  logic [7:0]  DATA_OUT;
  logic [63:0] PORT_OUT;
  logic        IRQ;

  data_mem_io #(
    .DATA_W (8),
    .ADDR_W (8),
    .N_PORTS(N),
    .IO_BASE(B)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .WRITE_MEM(WRITE_MEM),
    .ADDRESS  (ADDRESS),
    .DATA_IN  (DATA_IN),
    .PORT_IN  (PORT_IN),
    .DATA_OUT (DATA_OUT),
    .PORT_OUT (PORT_OUT),
    .IRQ      (IRQ)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [256];
  bit          m_wr  [256];
  logic [63:0] m_pout;
  logic [7:0]  m_flags;
  logic [7:0]  m_mask;
  logic        m_irq;
  // History of PORT_IN values captured at each edge, oldest first.
  // Entry 1 is the sample software sees, entry 0 is the one before it.
  logic [63:0] m_samp [$];
  int          m_edges;

  function automatic bit is_io(input logic [7:0] a);
    return (int'(a) >= B) && (int'(a) < B + 4*N);
  endfunction

  task automatic model_reset();
    m_pout  = '0;
    m_flags = '0;
    m_mask  = '0;
    m_irq   = 1'b0;
    m_samp.delete();
    for (int k = 0; k < STAGES + 1; k++) m_samp.push_back('0);
    m_edges = 0;
  endtask

  task automatic model_edge(input bit rst, input bit we, input logic [7:0] a,
                            input logic [7:0] d, input logic [63:0] pin);
    logic [7:0]  evt;
    logic [7:0]  clr;
    logic [63:0] s_cur;
    logic [63:0] s_prv;
    logic        irq_n;
    int          off;
    if (rst) begin
      model_reset();
      return;
    end
    s_cur = m_samp[1];
    s_prv = m_samp[0];
    evt   = '0;
    if (m_edges >= STAGES + 1)
      for (int i = 0; i < N; i++)
        if (s_cur[i*8 +: 8] != s_prv[i*8 +: 8]) evt[i] = 1'b1;
    clr     = (we && a == A_FLAGS) ? d : 8'h00;
    irq_n   = |(m_flags & m_mask);
    m_flags = (m_flags & ~clr) | evt;
    if (we && a == A_MASK) m_mask = d;
    m_irq = irq_n;
    if (we) begin
      if (!is_io(a)) begin
        m_mem[a] = d;
        m_wr[a]  = 1'b1;
      end else begin
        off = int'(a) - B;
        if (off < N) m_pout[off*8 +: 8] = d;
      end
    end
    m_samp.push_back(pin);
    void'(m_samp.pop_front());
    if (m_edges < STAGES + 1) m_edges++;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int          off;
    logic [63:0] s;
    if (!is_io(a)) return m_mem[a];
    off = int'(a) - B;
    s   = m_samp[1];
    if (off < N)       return m_pout[off*8 +: 8];
    if (off < 2*N)     return s[(off-N)*8 +: 8];
    if (off == 2*N)    return m_flags;
    if (off == 2*N+1)  return m_mask;
    return 8'h00;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read against a fixed expected value.
  task automatic rd_c(input string tag, input logic [7:0] a, input logic [7:0] exp);
    ADDRESS = a;
    #1;
    chk(tag, DATA_OUT, exp);
  endtask

  // Read against the model (RAM words never written are skipped).
  task automatic rd_m(input string tag, input logic [7:0] a);
    ADDRESS = a;
    #1;
    if (is_io(a) || m_wr[a]) chk(tag, DATA_OUT, m_read(a));
  endtask

  task automatic st_chk(input string tag);
    chk({tag, "_pout"}, PORT_OUT, m_pout);
    chk({tag, "_irq"}, IRQ, m_irq);
  endtask

  // One clock edge with the given control inputs; model follows the same edge.
  task automatic step(input bit rst, input bit we, input logic [7:0] a, input logic [7:0] d);
    RESET     = rst;
    WRITE_MEM = we;
    ADDRESS   = a;
    DATA_IN   = d;
    @(posedge CLK);
    model_edge(rst, we, a, d, PORT_IN);
    #1;
    RESET     = 1'b0;
    WRITE_MEM = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    for (int k = 0; k < 256; k++) begin
      m_mem[k] = '0;
      m_wr[k]  = 1'b0;
    end
    model_reset();

    // Reset state
    step(1, 0, 8'h00, 8'h00);
    chk("rst_pout", PORT_OUT, 64'h0);
    chk("rst_irq", IRQ, 1'b0);
    rd_c("rst_flags", A_FLAGS, 8'h00);
    rd_c("rst_mask", A_MASK, 8'h00);
    idle(STAGES + 2);

    // RAM and reserved space
    step(0, 1, 8'h10, 8'h5A);
    step(0, 1, 8'hF8, 8'h33);
    step(0, 1, 8'hDF, 8'h77);
    step(0, 1, 8'hFC, 8'h77);
    rd_c("ram_10", 8'h10, 8'h5A);
    rd_c("res_F8", 8'hF8, 8'h00);
    rd_c("ram_DF", 8'hDF, 8'h77);
    rd_c("res_FC", 8'hFC, 8'h00);

    // Output ports, read-only input ports
    step(0, 1, 8'hE5, 8'hC3);
    chk("pout5", PORT_OUT[47:40], 8'hC3);
    rd_c("rd_E5", 8'hE5, 8'hC3);
    PORT_IN[15:8] = 8'h5B;
    idle(STAGES + 1);
    step(0, 1, 8'hE9, 8'hFF);
    rd_c("rd_E9", 8'hE9, 8'h5B);
    st_chk("s2");

    // Events on port 2 with mask 04
    idle(STAGES + 2);
    step(0, 1, A_FLAGS, 8'hFF);
    step(0, 1, A_MASK, 8'h04);
    rd_c("s3_clean", A_FLAGS, 8'h00);
    PORT_IN[23:16] = 8'h11;
    for (int j = 0; j <= STAGES; j++) begin
      step(0, 0, 8'h00, 8'h00);
      rd_c("s3_flag", A_FLAGS, (j == STAGES) ? 8'h04 : 8'h00);
      chk("s3_irq_low", IRQ, 1'b0);
    end
    step(0, 0, 8'h00, 8'h00);
    chk("s3_irq_high", IRQ, 1'b1);
    step(0, 1, A_FLAGS, 8'h04);
    rd_c("s3_cleared", A_FLAGS, 8'h00);
    chk("s3_irq_hold", IRQ, 1'b1);
    step(0, 0, 8'h00, 8'h00);
    chk("s3_irq_drop", IRQ, 1'b0);

    // Set wins over clear on the same edge
    PORT_IN[23:16] = 8'h22;
    idle(STAGES);
    step(0, 1, A_FLAGS, 8'h04);
    rd_c("s4_set_wins", A_FLAGS, 8'h04);
    st_chk("s4");
    step(0, 1, A_FLAGS, 8'hFF);

    // Masking
    step(0, 1, A_MASK, 8'h00);
    step(0, 1, A_FLAGS, 8'hFF);
    PORT_IN[7:0]   = PORT_IN[7:0] ^ 8'h01;
    PORT_IN[63:56] = PORT_IN[63:56] ^ 8'h80;
    idle(STAGES + 1);
    rd_c("s6_flags", A_FLAGS, 8'h81);
    chk("s6_irq_masked", IRQ, 1'b0);
    step(0, 0, 8'h00, 8'h00);
    chk("s6_irq_masked2", IRQ, 1'b0);
    step(0, 1, A_MASK, 8'h80);
    chk("s6_irq_wr_edge", IRQ, 1'b0);
    step(0, 0, 8'h00, 8'h00);
    chk("s6_irq_high", IRQ, 1'b1);

    // Reset mid-operation, overriding a concurrent write
    PORT_IN = 64'hA1B2_C3D4_E5F6_0718;
    step(0, 1, 8'hE0, 8'hAA);
    step(0, 1, A_MASK, 8'hFF);
    step(1, 1, 8'hE0, 8'h55);
    chk("s5_pout", PORT_OUT, 64'h0);
    chk("s5_irq", IRQ, 1'b0);
    rd_c("s5_flags", A_FLAGS, 8'h00);
    rd_c("s5_mask", A_MASK, 8'h00);
    rd_c("s5_in0", 8'hE8, 8'h00);
    for (int j = 0; j < STAGES + 3; j++) begin
      step(0, 0, 8'h00, 8'h00);
      rd_c("s5_no_spurious", A_FLAGS, 8'h00);
    end
    rd_c("s5_in0_filled", 8'hE8, 8'h18);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      int p;
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, N - 1);
        PORT_IN[p*8 +: 8] = 8'($urandom);
      end
      ra = ($urandom_range(0, 1) == 1) ? 8'(B + $urandom_range(0, 4*N - 1)) : 8'($urandom);
      step(0, 1'($urandom_range(0, 1)), ra, 8'($urandom));
      st_chk("rnd");
      ra = ($urandom_range(0, 1) == 1) ? 8'(B + $urandom_range(0, 4*N - 1)) : 8'($urandom);
      rd_m("rnd_rd", ra);
      rd_m("rnd_flags", A_FLAGS);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
